// File: rtl/pc.sv
// Program counter for the pipelined MIPS fetch stage: advances by STEP each
// clock or loads a redirect target; reset has priority over redirect.
module pc #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [31:0] STEP       = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Jumpsign,
    input  logic [31:0] JumpAddr,
    output logic [31:0] PC
);

    // Power-up value makes the fetch address defined before the first reset pulse.
    logic [31:0] pc_q = RESET_ADDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else if (Jumpsign) begin
            pc_q <= JumpAddr;
        end else begin
            pc_q <= pc_q + STEP;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: per-cycle compare against a reference model,
// directed sequences with literal expectations, then randomized traffic.
module tb_pc;

    localparam logic [31:0] RST_A = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Jumpsign;
    logic [31:0] JumpAddr;
    logic [31:0] PC;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_pc = RST_A;
    logic        compare_on = 1'b0;

    pc #(.RESET_ADDR(32'h0000_3000), .STEP(32'd4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Jumpsign (Jumpsign),
        .JumpAddr (JumpAddr),
        .PC       (PC)
    );

    always #5 clk = ~clk;

    // Reference: what the fetch address must become at each edge.
    always @(posedge clk) begin
        if (reset)         model_pc <= RST_A;
        else if (Jumpsign) model_pc <= JumpAddr;
        else               model_pc <= model_pc + 32'd4;
    end

    always @(negedge clk) begin
        if (compare_on) begin
            checks++;
            if (PC !== model_pc) begin
                errors++;
                $display("FAIL model_cmp t=%0t PC=%h expected=%h", $time, PC, model_pc);
            end
        end
    end

    task automatic expect_pc(input string name, input logic [31:0] want);
        checks++;
        if (PC !== want) begin
            errors++;
            $display("FAIL %s PC=%h expected=%h", name, PC, want);
        end
    endtask

    // Drive inputs for the next edge, then return at the following falling edge.
    task automatic step(input logic r, input logic j, input logic [31:0] a);
        reset    = r;
        Jumpsign = j;
        JumpAddr = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Same as step, but toggles all inputs between edges to prove they are ignored.
    task automatic glitch_step(input logic r, input logic j, input logic [31:0] a);
        reset    = r;
        Jumpsign = j;
        JumpAddr = a;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        Jumpsign = 1'b1;
        JumpAddr = $urandom;
        #2;
        reset    = r;
        Jumpsign = j;
        JumpAddr = $urandom;
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        Jumpsign = 1'b0;
        JumpAddr = 32'h0;
        #1;
        expect_pc("powerup", 32'h0000_3000);
        compare_on = 1'b1;

        step(0, 0, 32'h0); expect_pc("seq1", 32'h0000_3004);
        step(0, 0, 32'h0); expect_pc("seq2", 32'h0000_3008);
        step(0, 0, 32'h0); expect_pc("seq3", 32'h0000_300C);
        step(0, 0, 32'h0); expect_pc("seq4", 32'h0000_3010);

        step(1, 0, 32'h0); expect_pc("reset_e1", 32'h0000_3000);
        step(1, 0, 32'h0); expect_pc("reset_e2", 32'h0000_3000);
        step(0, 0, 32'h0); expect_pc("reset_rel", 32'h0000_3004);

        step(0, 1, 32'h0000_3100); expect_pc("jump", 32'h0000_3100);
        step(0, 0, 32'h0);         expect_pc("jump_p4", 32'h0000_3104);
        step(0, 0, 32'h0);         expect_pc("jump_p8", 32'h0000_3108);

        step(1, 1, 32'h0000_4000); expect_pc("rst_over_jump", 32'h0000_3000);

        step(0, 1, 32'hFFFF_FFF8); expect_pc("wrap_a", 32'hFFFF_FFF8);
        step(0, 0, 32'h0);         expect_pc("wrap_b", 32'hFFFF_FFFC);
        step(0, 0, 32'h0);         expect_pc("wrap_c", 32'h0000_0000);

        glitch_step(0, 0, 32'hDEAD_BEEF); expect_pc("glitch1", 32'h0000_0004);
        glitch_step(0, 0, 32'h1234_5678); expect_pc("glitch2", 32'h0000_0008);

        step(0, 1, 32'h0000_3200); expect_pc("b2b_1", 32'h0000_3200);
        step(0, 1, 32'h0000_3300); expect_pc("b2b_2", 32'h0000_3300);
        step(0, 1, 32'h0000_3300); expect_pc("hold_jump", 32'h0000_3300);

        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        j;
            logic [31:0] a;
            r = ($urandom_range(0, 15) == 0);
            j = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | {28'h0, $urandom_range(0, 15) == 0 ? 4'hC : 4'h8})
                                            : $urandom;
            if (i % 7 == 3) glitch_step(r, j, a);
            else            step(r, j, a);
        end

        compare_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
